dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//   Two-port arbiter/sequencer in front of the single-port 64-word data memory.
//   Port 0 = core load/store unit, port 1 = debug/DMA loader; shares one memory.
//   Accepts valid/ready-style requests, round-robin grants, drives memory
//   read/write strobes, returns registered read data to the granted requester.
// PARAMETERS
//   DATA_W     32   data width, both ports and memory
//   ADDR_W     32   requester byte-address width
//   MEM_WORDS  64   memory depth in words (power of 2); IDX_W = clog2(MEM_WORDS)
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-low reset
//   req0/req1  in   1        request valid, port 0/1
//   we0/we1    in   1        1 = write, 0 = read
//   addr0/1    in   ADDR_W   byte address
//   wdata0/1   in   DATA_W   write data
//   gnt0/gnt1  out  1        one-cycle accept pulse
//   rvalid0/1  out  1        one-cycle completion pulse (reads and writes)
//   rdata0/1   out  DATA_W   read data, valid with rvalid
//   err0/err1  out  1        completion carried an error, valid with rvalid
//   mem_read   out  1        memory read strobe
//   mem_write  out  1        memory write strobe (sampled at next posedge)
//   mem_addr   out  32       memory word index, zero-extended
//   mem_wdata  out  DATA_W   memory write data
//   mem_rdata  in   DATA_W   memory read data (combinational from mem_addr)
// BEHAVIOUR
//   - Reset (rst=0, async): state=IDLE; all gnt/rvalid/err/mem_read/mem_write=0;
//     rdata*/mem_addr/mem_wdata=0; rr_last=1 (port 0 wins first tie).
//     In-flight transaction dropped: no rvalid, no memory write after reset.
//   - FSM: IDLE -> ACCESS on grant; ACCESS -> RESP always;
//     RESP -> ACCESS if a new grant issues, else IDLE.
//   - Grants issue only in IDLE or RESP. One req: grant it. Both: grant
//     !rr_last; rr_last <= granted port. gnt is combinational from state/req.
//   - Grant cycle t: we/addr/wdata latched at posedge. Requester holds request
//     stable until gnt. Requester must drop req the cycle after gnt unless it
//     issues a new request.
//   - ACCESS (t+1): mem_addr = addr[IDX_W+1:2]. Read: mem_read=1, mem_rdata
//     captured at end of cycle. Write: mem_write=1, mem_wdata = latched data.
//   - RESP (t+2): rvalid of owning port=1 for one cycle. rdata=captured word
//     (0 for writes). rdata holds until the next completion on that port.
//   - Back-to-back: sustained throughput 1 access / 2 cycles.
//   - Error: addr[1:0]!=0 or addr[ADDR_W-1:IDX_W+2]!=0 -> no strobe in ACCESS,
//     RESP gives rvalid=1, err=1, rdata=0. Memory is unchanged.
//   - mem_read and mem_write never both 1; both 0 outside ACCESS.
//   - Request arriving while busy: waits, no gnt, no loss.
// CONFIGURATION
//   DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins simultaneous requests;
//     rr_last not updated. Port 1 can starve.
//   Undefined (default): round-robin as above.
// TESTING
//   1 Reset released, idle -> all outputs 0; no mem strobes for 10 cycles.
//   2 Port0 write addr=0x10 data=0xDEAD_BEEF, then read 0x10 -> mem_addr=4
//     both accesses; rvalid0 at t+2 with rdata0=0xDEADBEEF, err0=0.
//   3 req0 and req1 (reads 0x4, 0x8) held together for 8 cycles -> gnts
//     alternate 0,1,0,1; with DMEM_ARB_FIXED_PRIO_EN all gnts go to port 0.
//   4 Port1 read addr=0x6 (misaligned) and addr=0x100 (range) -> rvalid1 with
//     err1=1, rdata1=0; mem_read stays 0.
//   5 rst asserted mid-ACCESS of a write -> mem_write drops immediately;
//     target word unchanged; no rvalid after release.
//   6 Port0 issues 4 back-to-back reads of 0x0..0xC -> gnt0 every 2 cycles;
//     rvalid0 pulses carry words 0..3 in order.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a single-port data memory.
// Port 0 is the core load/store unit, port 1 the debug/DMA loader.
// Each accepted request takes one ACCESS cycle and then one RESP cycle.
// A new grant may issue during RESP, so back-to-back requests complete
// at one access every two cycles.
// Configuration macro: DMEM_ARB_FIXED_PRIO_EN. When it is defined, port 0 always
// wins simultaneous requests. When it is undefined (the default), simultaneous
// requests are granted round-robin.
module dmem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              rvalid0_o,
  output logic              rvalid1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              canGrant;
  logic              pick1;
  logic              anyGnt;
  logic              accessOk;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] capWord;

  // Grant selection: only in IDLE or RESP; pick1 means port 1 wins this cycle
  always_comb begin
    canGrant = (state_q == IDLE) || (state_q == RESP);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    pick1 = canGrant & req1_i & ~req0_i;
`else
    pick1 = canGrant & req1_i & (~req0_i | ~rr_last_q);
`endif
    gnt1_o = pick1;
    gnt0_o = canGrant & req0_i & ~pick1;
    anyGnt = gnt0_o | gnt1_o;
  end

  // Next-state logic: FSM sequencing, request latching and read data capture
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    err_d     = err_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    selAddr   = pick1 ? addr1_i : addr0_i;
    accessOk  = (state_q == ACCESS) && !err_q;
    capWord   = (accessOk && !we_q) ? mem_rdata_i : '0;

    case (state_q)
      IDLE:    state_d = anyGnt ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = anyGnt ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase

    if (anyGnt) begin
      owner_d = pick1;
      we_d    = pick1 ? we1_i : we0_i;
      wdata_d = pick1 ? wdata1_i : wdata0_i;
      idx_d   = selAddr[IDX_W+1:2];
      err_d   = (|selAddr[1:0]) | (|selAddr[ADDR_W-1:IDX_W+2]);
`ifndef DMEM_ARB_FIXED_PRIO_EN
      rr_last_d = pick1;
`endif
    end

    if (state_q == ACCESS) begin
      if (owner_q) rdata1_d = capWord;
      else         rdata0_d = capWord;
    end
  end

  // State registers; reset drops any in-flight transaction
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      err_q     <= err_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Output decode: memory strobes only in a legal ACCESS, completions in RESP
  always_comb begin
    mem_read_o  = accessOk & ~we_q;
    mem_write_o = accessOk & we_q;
    mem_addr_o  = (state_q == ACCESS) ? {{(32-IDX_W){1'b0}}, idx_q} : '0;
    mem_wdata_o = mem_write_o ? wdata_q : '0;
    rvalid0_o   = (state_q == RESP) & ~owner_q;
    rvalid1_o   = (state_q == RESP) & owner_q;
    err0_o      = rvalid0_o & err_q;
    err1_o      = rvalid1_o & err_q;
    rdata0_o    = rdata0_q;
    rdata1_o    = rdata1_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a 64-word memory model.
// Expected responses and memory strobes are queued at grant time from a reference
// memory image; a monitor on the falling edge pops and compares them.
module tb_dmem_arbiter;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } strobe_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [64];
  logic [31:0] refMem [64];
  resp_t       q0 [$];
  resp_t       q1 [$];
  strobe_t     qs [$];

  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;

  dmem_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req0_i      (req0),
    .req1_i      (req1),
    .we0_i       (we0),
    .we1_i       (we1),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .rvalid0_o   (rvalid0),
    .rvalid1_o   (rvalid1),
    .rdata0_o    (rdata0),
    .rdata1_o    (rdata1),
    .err0_o      (err0),
    .err1_o      (err1),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Memory model: combinational read, write sampled at posedge
  assign mem_rdata = mem[mem_addr[5:0]];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    forever begin
      @(posedge clk);
      if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison with counting
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue the expected completion and strobe of an accepted request
  task automatic pushExpect(input int port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
    resp_t   r;
    strobe_t s;
    logic    bad;
    bad = (addr[1:0] != 2'b00) || (addr[31:8] != 24'h0);
    if (bad) begin
      r = '{err: 1'b1, data: 32'h0};
    end else if (we) begin
      refMem[addr[7:2]] = wdata;
      r = '{err: 1'b0, data: 32'h0};
      s = '{wr: 1'b1, addr: {26'h0, addr[7:2]}, data: wdata};
      qs.push_back(s);
    end else begin
      r = '{err: 1'b0, data: refMem[addr[7:2]]};
      s = '{wr: 1'b0, addr: {26'h0, addr[7:2]}, data: 32'h0};
      qs.push_back(s);
    end
    if (port == 0) q0.push_back(r);
    else           q1.push_back(r);
  endtask

  // Present one request, wait (bounded) for its grant, then drop it
  task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, output int grantCycle);
    bit got;
    got = 1'b0;
    grantCycle = -1;
    if (port == 0) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; end
    else           begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if ((port == 0) ? gnt0 : gnt1) begin
        got = 1'b1;
        grantCycle = cycleCount;
        pushExpect(port, we, addr, wdata);
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    if (!got) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL grant_timeout: got no gnt on port %0d expected gnt within 20 cycles", port);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compare every completion and memory strobe against the scoreboard
  always @(negedge clk) begin
    resp_t   r;
    strobe_t s;
    if (rst_n) begin
      if (rvalid0) begin
        if (q0.size() == 0) checkOutput("unexpected_rvalid0", 32'd1, 32'd0);
        else begin
          r = q0.pop_front();
          checkOutput("rdata0", rdata0, r.data);
          checkOutput("err0", {31'h0, err0}, {31'h0, r.err});
        end
      end
      if (rvalid1) begin
        if (q1.size() == 0) checkOutput("unexpected_rvalid1", 32'd1, 32'd0);
        else begin
          r = q1.pop_front();
          checkOutput("rdata1", rdata1, r.data);
          checkOutput("err1", {31'h0, err1}, {31'h0, r.err});
        end
      end
      if (mem_read && mem_write) checkOutput("strobe_exclusive", 32'd1, 32'd0);
      if (mem_read || mem_write) begin
        if (qs.size() == 0) checkOutput("unexpected_strobe", 32'd1, 32'd0);
        else begin
          s = qs.pop_front();
          checkOutput("strobe_kind", {31'h0, mem_write}, {31'h0, s.wr});
          checkOutput("mem_addr", mem_addr, s.addr);
          if (s.wr) checkOutput("mem_wdata", mem_wdata, s.data);
        end
      end
    end
  end

  // Directed test sequence
  initial begin
    int gc;
    int prevGc;
    int nGnt;
    int port;
    int expOrder [4];
`ifdef DMEM_ARB_FIXED_PRIO_EN
    expOrder = '{0, 0, 0, 0};
`else
    expOrder = '{0, 1, 0, 1};
`endif
    for (int i = 0; i < 64; i++) refMem[i] = 32'hA500_0000 | i;

    // Test 1: reset release, everything quiet for 10 cycles
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_rdata0", rdata0, 32'h0);
    checkOutput("reset_rdata1", rdata1, 32'h0);
    checkOutput("reset_mem_addr", mem_addr, 32'h0);
    checkOutput("reset_mem_wdata", mem_wdata, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle_ctrl", {24'h0, gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_read, mem_write}, 32'h0);
    end
    @(posedge clk); #1;

    // Test 3: both ports request together for 8 cycles
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
    nGnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (gnt0 && gnt1) checkOutput("gnt_exclusive", 32'd1, 32'd0);
      if (gnt0 || gnt1) begin
        port = gnt1 ? 1 : 0;
        if (nGnt < 4) checkOutput("arb_order", port, expOrder[nGnt]);
        pushExpect(port, 1'b0, (port == 1) ? 32'h8 : 32'h4, 32'h0);
        nGnt++;
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("arb_grant_count", nGnt, 32'd4);
    idleCycles(4);

    // Test 2: port 0 write then read back at word 4
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, gc);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, gc);
    idleCycles(4);
    checkOutput("rdata0_hold", rdata0, 32'hDEAD_BEEF);

    // Test 4: port 1 misaligned and out-of-range reads
    applyStimulus(1, 1'b0, 32'h6, 32'h0, gc);
    applyStimulus(1, 1'b0, 32'h100, 32'h0, gc);
    idleCycles(4);

    // Test 6: four back-to-back port 0 reads
    prevGc = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, 32'(i * 4), 32'h0, gc);
      if (i > 0) checkOutput("b2b_spacing", gc - prevGc, 32'd2);
      prevGc = gc;
    end
    idleCycles(4);

    // Test 5: reset in the middle of a write access
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h1234_5678;
    @(negedge clk);
    checkOutput("rst_test_gnt0", {31'h0, gnt0}, 32'd1);
    qs.push_back('{wr: 1'b1, addr: 32'd8, data: 32'h1234_5678});
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_write", {31'h0, mem_write}, 32'd0);
    checkOutput("rst_rdata0", rdata0, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(6);
    checkOutput("rst_word_kept", mem[8], 32'hA500_0008);

    // Everything queued must have been consumed
    checkOutput("q0_drained", q0.size(), 32'd0);
    checkOutput("q1_drained", q1.size(), 32'd0);
    checkOutput("qs_drained", qs.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
